// File: rtl/ft_bus_pkg.sv
// Shared constants for the FT245-style bus scheduler: state encoding,
// default bus widths and TX channel indices.
package ft_bus_pkg;

    localparam int FT_DATA_W = 16;
    localparam int FT_BE_W   = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RX_OE    = 3'd1;
    localparam logic [2:0] ST_RX_RD    = 3'd2;
    localparam logic [2:0] ST_RX_END   = 3'd3;
    localparam logic [2:0] ST_TX       = 3'd4;
    localparam logic [2:0] ST_TX_DRAIN = 3'd5;

    localparam logic CH_ADC  = 1'b0;
    localparam logic CH_STAT = 1'b1;

endpackage

// File: rtl/ft_rr_arb2.sv
// Two-way round-robin arbiter. last_grant doubles as the active grant while
// a TX burst is running, so it only moves when a new burst is taken.
module ft_rr_arb2
    import ft_bus_pkg::*;
(
    input  logic       i_ft_clk,
    input  logic       i_rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       next_grant,
    output logic       last_grant
);

    always_comb begin
        // NOTE: default assignment first so every path drives next_grant and no latch is inferred.
        next_grant = last_grant;
        if (last_grant == CH_ADC)
            next_grant = req[CH_STAT] ? CH_STAT : CH_ADC;
        else
            next_grant = req[CH_ADC] ? CH_ADC : CH_STAT;
    end

    // Reset to STAT so the ADC stream wins the first arbitration.
    always_ff @(posedge i_ft_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_grant <= CH_STAT;
        else if (take)
            last_grant <= next_grant;
    end

endmodule

// File: rtl/ft_bus_sched.sv
// FT245 synchronous FIFO bus owner: RX command stream has priority, two TX
// requesters share the write side via round-robin bounded bursts.
module ft_bus_sched
    import ft_bus_pkg::*;
#(
    parameter int DATA_W    = FT_DATA_W,
    parameter int BE_W      = FT_BE_W,
    parameter int BURST_MAX = 256,
    parameter int CNT_W     = 9
) (
    input  logic              i_ft_clk,
    input  logic              i_rst_n,
    input  logic              i_ft_rxf_n,
    input  logic              i_ft_txe_n,
    output logic              o_ft_oe_n,
    output logic              o_ft_rd_n,
    output logic              o_ft_wr_n,
    inout  wire  [BE_W-1:0]   io_ft_be,
    inout  wire  [DATA_W-1:0] io_ft_data,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    input  logic              i_tx0_valid,
    input  logic [DATA_W-1:0] i_tx0_data,
    output logic              o_tx0_ready,
    input  logic              i_tx1_valid,
    input  logic [DATA_W-1:0] i_tx1_data,
    output logic              o_tx1_ready,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    logic [2:0]        state;
    logic [CNT_W-1:0]  burst_cnt;
    logic [DATA_W-1:0] tx_reg;

    logic              grant;
    logic              next_grant;
    logic              tx_start;
    logic              valid_g;
    logic [DATA_W-1:0] data_g;
    logic              ready_g;
    logic              tx_load;
    logic              ft_accept;

    ft_rr_arb2 u_arb (
        .i_ft_clk   (i_ft_clk),
        .i_rst_n    (i_rst_n),
        .req        ({i_tx1_valid, i_tx0_valid}),
        .take       (tx_start),
        .next_grant (next_grant),
        .last_grant (grant)
    );

    assign tx_start = (state == ST_IDLE) && i_ft_rxf_n && !i_ft_txe_n
                      && (i_tx0_valid || i_tx1_valid);

    assign valid_g = (grant == CH_STAT) ? i_tx1_valid : i_tx0_valid;
    assign data_g  = (grant == CH_STAT) ? i_tx1_data  : i_tx0_data;

    // A pending word may only be replaced on an edge where the FT takes it.
    assign ready_g = (state == ST_TX) && (burst_cnt < BURST_LIM) && i_ft_rxf_n
                     && (o_ft_wr_n || !i_ft_txe_n);
    assign tx_load   = ready_g && valid_g;
    assign ft_accept = !o_ft_wr_n && !i_ft_txe_n;

    assign o_tx0_ready = ready_g && (grant == CH_ADC);
    assign o_tx1_ready = ready_g && (grant == CH_STAT);
    assign o_busy      = (state != ST_IDLE);

    assign io_ft_data = o_ft_oe_n ? tx_reg          : {DATA_W{1'bz}};
    assign io_ft_be   = o_ft_oe_n ? {BE_W{1'b1}}    : {BE_W{1'bz}};

    always_ff @(posedge i_ft_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            tx_reg     <= '0;
            o_ft_oe_n  <= 1'b1;
            o_ft_rd_n  <= 1'b1;
            o_ft_wr_n  <= 1'b1;
            o_rx_valid <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in the case override this pulse default.
            o_rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!i_ft_rxf_n) begin
                        state     <= ST_RX_OE;
                        o_ft_oe_n <= 1'b0;
                        o_ft_rd_n <= 1'b1;
                    end else if (tx_start) begin
                        state     <= ST_TX;
                        burst_cnt <= '0;
                    end
                end
                ST_RX_OE: begin
                    if (!i_ft_rxf_n) begin
                        state     <= ST_RX_RD;
                        o_ft_rd_n <= 1'b0;
                    end else begin
                        state <= ST_RX_END;
                    end
                end
                ST_RX_RD: begin
                    if (!i_ft_rxf_n) begin
                        o_rx_data  <= io_ft_data;
                        o_rx_valid <= 1'b1;
                    end else begin
                        o_ft_rd_n <= 1'b1;
                        state     <= ST_RX_END;
                    end
                end
                ST_RX_END: begin
                    o_ft_oe_n <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_TX: begin
                    if (tx_load) begin
                        tx_reg    <= data_g;
                        o_ft_wr_n <= 1'b0;
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end else if (ft_accept) begin
                        o_ft_wr_n <= 1'b1;
                    end
                    if (!ready_g || !valid_g)
                        state <= ST_TX_DRAIN;
                end
                ST_TX_DRAIN: begin
                    if (ft_accept)
                        o_ft_wr_n <= 1'b1;
                    if (o_ft_wr_n)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft_bus_sched.sv
// Directed/randomized bench for ft_bus_sched: an FT host model plus queue-based
// TX sources, with written/received words compared against a round-robin model.
module tb_ft_bus_sched;

    typedef bit              bq_t[$];
    typedef int              iq_t[$];
    typedef logic [15:0]     wq_t[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic        clk;
    logic        rst_n;
    logic        rxf_n, txe_n, rxf_b_n;
    logic [15:0] host_word;

    logic        tx0_valid, tx1_valid, tx0_ready, tx1_ready;
    logic [15:0] tx0_data, tx1_data;
    logic        oe_n, rd_n, wr_n, rx_valid, busy;
    logic [15:0] rx_data;
    wire  [15:0] ft_data;
    wire  [1:0]  ft_be;

    logic        b0_valid, b1_valid, b0_ready, b1_ready;
    logic [15:0] b0_data, b1_data;
    logic        oe_b_n, rd_b_n, wr_b_n, rx_b_valid, busy_b;
    logic [15:0] rx_b_data;
    wire  [15:0] ft_data_b;
    wire  [1:0]  ft_be_b;

    assign ft_data = oe_n ? 16'hzzzz : host_word;
    assign ft_be   = oe_n ? 2'bzz    : 2'b11;

    ft_bus_sched u_dut (
        .i_ft_clk(clk), .i_rst_n(rst_n), .i_ft_rxf_n(rxf_n), .i_ft_txe_n(txe_n),
        .o_ft_oe_n(oe_n), .o_ft_rd_n(rd_n), .o_ft_wr_n(wr_n),
        .io_ft_be(ft_be), .io_ft_data(ft_data),
        .o_rx_valid(rx_valid), .o_rx_data(rx_data),
        .i_tx0_valid(tx0_valid), .i_tx0_data(tx0_data), .o_tx0_ready(tx0_ready),
        .i_tx1_valid(tx1_valid), .i_tx1_data(tx1_data), .o_tx1_ready(tx1_ready),
        .o_busy(busy)
    );

    ft_bus_sched #(.BURST_MAX(4), .CNT_W(3)) u_dut_b (
        .i_ft_clk(clk), .i_rst_n(rst_n), .i_ft_rxf_n(rxf_b_n), .i_ft_txe_n(txe_n),
        .o_ft_oe_n(oe_b_n), .o_ft_rd_n(rd_b_n), .o_ft_wr_n(wr_b_n),
        .io_ft_be(ft_be_b), .io_ft_data(ft_data_b),
        .o_rx_valid(rx_b_valid), .o_rx_data(rx_b_data),
        .i_tx0_valid(b0_valid), .i_tx0_data(b0_data), .o_tx0_ready(b0_ready),
        .i_tx1_valid(b1_valid), .i_tx1_data(b1_data), .o_tx1_ready(b1_ready),
        .o_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wq_t q0, q1, qb0, qb1, host_q, wr_log, wr_b_log, rx_log;
    bq_t h_oe, h_rd, h_wr, h_busy;
    iq_t h_nwr;
    logic        s_oe, s_rd, s_wr, s_busy, s_busy_b, s_r0, s_r1;
    logic [15:0] s_data;
    int n_fire0, n_fire1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        tx0_valid = (q0.size() != 0);  tx0_data = (q0.size() != 0)  ? q0[0]  : 16'h0;
        tx1_valid = (q1.size() != 0);  tx1_data = (q1.size() != 0)  ? q1[0]  : 16'h0;
        b0_valid  = (qb0.size() != 0); b0_data  = (qb0.size() != 0) ? qb0[0] : 16'h0;
        b1_valid  = (qb1.size() != 0); b1_data  = (qb1.size() != 0) ? qb1[0] : 16'h0;
        rxf_n     = (host_q.size() == 0);
        host_word = (host_q.size() != 0) ? host_q[0] : 16'h0;
    endtask

    // One bus cycle: sample at the falling edge, then update sources after the rising edge.
    task automatic cycle();
        logic f0, f1, fb0, fb1, frx;
        @(negedge clk);
        s_oe = oe_n; s_rd = rd_n; s_wr = wr_n; s_busy = busy; s_busy_b = busy_b;
        s_r0 = tx0_ready; s_r1 = tx1_ready; s_data = ft_data;
        f0  = tx0_valid && tx0_ready;
        f1  = tx1_valid && tx1_ready;
        fb0 = b0_valid && b0_ready;
        fb1 = b1_valid && b1_ready;
        frx = !rd_n && !rxf_n;
        if (!wr_n && !txe_n) begin
            wr_log.push_back(ft_data);
            check("be", ft_be, 2'b11);
        end
        if (!wr_b_n && !txe_n) begin
            wr_b_log.push_back(ft_data_b);
            check("be_b", ft_be_b, 2'b11);
        end
        if (rx_valid) rx_log.push_back(rx_data);
        check("oe_wr_excl", !oe_n && !wr_n, 0);
        check("ready_excl", tx0_ready && tx1_ready, 0);
        check("ready_excl_b", b0_ready && b1_ready, 0);
        check("b_no_rx", {oe_b_n, rd_b_n, rx_b_valid}, 3'b110);
        h_oe.push_back(oe_n); h_rd.push_back(rd_n); h_wr.push_back(wr_n);
        h_busy.push_back(busy); h_nwr.push_back(wr_log.size());
        @(posedge clk);
        #1;
        if (f0)  begin q0.delete(0);  n_fire0++; end
        if (f1)  begin q1.delete(0);  n_fire1++; end
        if (fb0) qb0.delete(0);
        if (fb1) qb1.delete(0);
        if (frx && host_q.size() != 0) host_q.delete(0);
        apply();
    endtask

    task automatic clear_hist();
        h_oe.delete(); h_rd.delete(); h_wr.delete(); h_busy.delete(); h_nwr.delete();
    endtask

    task automatic settle(input int max_cyc);
        int idle_run = 0;
        int n = 0;
        while (n < max_cyc && idle_run < 2) begin
            cycle();
            n++;
            if (!s_busy && !s_busy_b && q0.size() == 0 && q1.size() == 0 && qb0.size() == 0
                && qb1.size() == 0 && host_q.size() == 0)
                idle_run++;
            else
                idle_run = 0;
        end
        check("settle", idle_run >= 2, 1);
    endtask

    task automatic check_seq(input string tag, input wq_t got, input wq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
    endtask

    function automatic int find(input bq_t q, input bit v, input int from);
        if (from < 0) return -1;
        for (int i = from; i < q.size(); i++)
            if (q[i] == v) return i;
        return -1;
    endfunction

    function automatic int max_low_run(input bq_t q);
        int run = 0, best = 0;
        foreach (q[i]) begin
            run = (q[i] == 1'b0) ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    function automatic logic hb(input int i);
        return (i >= 0 && i < h_busy.size()) ? h_busy[i] : 1'bx;
    endfunction

    // Order words reach the FT when both sources hold all their words from the
    // start: alternate grants (ADC first), each burst up to 'burst' words.
    function automatic wq_t rr_order(input wq_t a, input wq_t b, input int burst);
        wq_t out;
        int  last = 1;
        int  g;
        while (a.size() + b.size() > 0) begin
            if (last == 0) g = (b.size() > 0) ? 1 : 0;
            else           g = (a.size() > 0) ? 0 : 1;
            for (int k = 0; k < burst; k++) begin
                if (g == 0 && a.size() > 0)      out.push_back(a.pop_front());
                else if (g == 1 && b.size() > 0) out.push_back(b.pop_front());
            end
            last = g;
        end
        return out;
    endfunction

    initial begin
        wq_t exp_a, exp_b, exp_rx, empty_q;
        int  guard, t0, t1, t2, t3, n_pre, cnt7;
        logic [15:0] w;

        rst_n = 1'b0; txe_n = 1'b1; rxf_b_n = 1'b1;
        apply();
        #12;
        check("rst_strobes", {oe_n, rd_n, wr_n}, 3'b111);
        check("rst_rx", {rx_valid, rx_data}, 17'h0);
        check("rst_bus", ft_data, 16'h0);
        check("rst_be", ft_be, 2'b11);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // RX burst of three fixed words.
        clear_hist(); rx_log.delete();
        exp_rx = '{16'h1123, 16'h2004, 16'h8155};
        host_q = exp_rx;
        apply();
        settle(40);
        t0 = find(h_oe, 0, 0); t1 = find(h_rd, 0, 0);
        t2 = find(h_rd, 1, t1); t3 = find(h_oe, 1, t0);
        check("rx_oe_lead", t1 - t0, 1);
        check("rx_oe_trail", t3 - t2, 1);
        check_seq("rx_words", rx_log, exp_rx);

        // TX0 stream of 0..4.
        txe_n = 1'b0;
        clear_hist(); wr_log.delete(); n_fire0 = 0;
        q0 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
        exp_a = q0;
        apply();
        settle(40);
        check("tx0_run", max_low_run(h_wr), 5);
        check_seq("tx0_words", wr_log, rr_order(exp_a, empty_q, 256));
        t0 = find(h_wr, 1, find(h_wr, 0, 0));
        check("tx0_drain", hb(t0), 1);
        check("tx0_idle", hb(t0 + 1), 0);

        // Skid: FT full while word 0x0007 is pending.
        clear_hist(); wr_log.delete();
        w = 16'($urandom) & 16'h7fff | 16'h0100;
        q0 = '{16'h0007, w};
        exp_a = q0;
        apply();
        guard = 0;
        while (wr_n !== 1'b0 && guard < 10) begin cycle(); guard++; end
        check("skid_load", wr_n, 0);
        txe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("skid_data", s_data, 16'h0007);
            check("skid_wr", s_wr, 0);
            check("skid_ready", s_r0, 0);
        end
        txe_n = 1'b0;
        settle(40);
        cnt7 = 0;
        foreach (wr_log[i]) if (wr_log[i] == 16'h0007) cnt7++;
        check("skid_once", cnt7, 1);
        check_seq("skid_words", wr_log, rr_order(exp_a, empty_q, 256));

        // Round-robin with 4-word bursts on the second instance.
        wr_b_log.delete();
        for (int i = 0; i < 8; i++) begin
            qb0.push_back(16'($urandom) & 16'h7fff);
            qb1.push_back(16'($urandom) | 16'h8000);
        end
        exp_a = qb0; exp_b = qb1;
        apply();
        settle(120);
        check_seq("rr_words", wr_b_log, rr_order(exp_a, exp_b, 4));

        // RX pre-empts a TX1 burst.
        clear_hist(); wr_log.delete(); rx_log.delete(); n_fire1 = 0;
        for (int i = 0; i < 6; i++) q1.push_back(16'($urandom) | 16'h8000);
        exp_b = q1;
        apply();
        guard = 0;
        while (n_fire1 < 2 && guard < 20) begin cycle(); guard++; end
        check("pre_start", n_fire1, 2);
        n_pre = n_fire1;
        clear_hist();
        exp_rx = '{16'($urandom), 16'($urandom)};
        host_q = exp_rx;
        apply();
        cycle();
        check("pre_ready", s_r1, 0);
        check("pre_pending", s_wr, 0);
        settle(80);
        t0 = find(h_wr, 1, 0); t1 = find(h_oe, 0, 0);
        check("pre_oe_gap", (t0 >= 0 && t1 >= 0 && t1 - t0 >= 1 && t1 - t0 <= 2), 1);
        check("pre_written", (t1 >= 0) ? h_nwr[t1] : -1, n_pre);
        check_seq("pre_words", wr_log, rr_order(empty_q, exp_b, 256));
        check_seq("pre_rx", rx_log, exp_rx);

        // Asynchronous reset in the middle of a TX0 burst.
        n_fire0 = 0;
        for (int i = 0; i < 6; i++) q0.push_back(16'($urandom) & 16'h7fff);
        apply();
        guard = 0;
        while (n_fire0 < 2 && guard < 20) begin cycle(); guard++; end
        check("ar_start", n_fire0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_strobes", {oe_n, rd_n, wr_n}, 3'b111);
        check("ar_bus", ft_data, 16'h0);
        check("ar_busy", busy, 0);
        q0.delete(); q1.delete();
        apply();
        cycle();
        rst_n = 1'b1;
        wr_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(16'($urandom) & 16'h7fff);
            q1.push_back(16'($urandom) | 16'h8000);
        end
        exp_a = q0; exp_b = q1;
        apply();
        settle(60);
        check("ar_first_grant", (wr_log.size() != 0) ? wr_log[0][15] : 1'bx, 0);
        check_seq("ar_words", wr_log, rr_order(exp_a, exp_b, 256));
        check("b_rx_data", rx_b_data, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ft_bus_sched.md
Name: ft_bus_sched

Overview:
- Owns the FT245-style synchronous FIFO bus: oe_n, rd_n, wr_n, be and the bidirectional data pins.
- Time-shares the bus between one host-to-FPGA command stream (RX) and two FPGA-to-host data requesters: TX0 (ADC samples) and TX1 (status words).
- RX has priority. The TX channels are round-robin arbitrated and limited to bounded bursts.
- Sits between the FT pins and the command decoder / stream generators in top.

Parameters:
- DATA_W, 16, FT data bus width.
- BE_W, 2, byte-enable width.
- BURST_MAX, 256, maximum TX words per grant.
- CNT_W, 9, burst counter width; must hold BURST_MAX.

Ports:
- i_ft_clk  in  1  FT bus clock; all logic on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ft_rxf_n  in  1  low = host data available.
- i_ft_txe_n  in  1  low = FT TX FIFO has space.
- o_ft_oe_n  out  1  FT output enable, registered.
- o_ft_rd_n  out  1  FT read strobe, registered.
- o_ft_wr_n  out  1  FT write strobe, registered.
- io_ft_be  inout  BE_W  byte enables.
- io_ft_data  inout  DATA_W  data pins.
- o_rx_valid  out  1  one-cycle pulse per received word.
- o_rx_data  out  DATA_W  received word.
- i_tx0_valid  in  1  TX0 word available.
- i_tx0_data  in  DATA_W  TX0 word.
- o_tx0_ready  out  1  TX0 word accepted this edge (comb).
- i_tx1_valid  in  1  TX1 word available.
- i_tx1_data  in  DATA_W  TX1 word.
- o_tx1_ready  out  1  TX1 word accepted this edge (comb).
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-low. On reset, immediately:
  - o_ft_oe_n=1, o_ft_rd_n=1, o_ft_wr_n=1;
  - o_rx_valid=0, o_rx_data=0, tx_reg=0;
  - state=IDLE, burst_cnt=0, last_grant=1, so TX0 wins first.
  - Reset mid-burst drops any pending TX word and any RX word in flight.
- Bus drive:
  - io_ft_data = tx_reg when o_ft_oe_n==1, else Z.
  - io_ft_be = all-ones when o_ft_oe_n==1, else Z.
- State machine states: IDLE, RX_OE, RX_RD, RX_END, TX, TX_DRAIN.
- IDLE:
  - If rxf_n==0: go to RX_OE and assert oe_n=0, rd_n=1. RX wins over TX on a simultaneous request.
  - Else if txe_n==0 and (tx0_valid or tx1_valid): go to TX and clear burst_cnt.
    - Grant goes to the channel that is not last_grant if it is valid, otherwise to the valid one.
    - last_grant is updated to the granted channel.
  - Else stay in IDLE.
- RX_OE: one turnaround cycle with oe_n=0. Next state RX_RD with rd_n=0 if rxf_n==0; otherwise RX_END.
- RX_RD:
  - On every edge with rxf_n==0: o_rx_data<=io_ft_data and o_rx_valid<=1 for one cycle. Latency is 1 cycle from sample.
  - When rxf_n==1: rd_n<=1 and go to RX_END. No word is captured on that edge.
  - RX has no backpressure and no word limit.
- RX_END: oe_n<=1, one bus-turnaround cycle, then IDLE.
- TX, ready and load:
  - ready_g = (state==TX) & (burst_cnt<BURST_MAX) & rxf_n & (wr_n==1 | txe_n==0), where g is the granted channel.
  - The other channel's ready is 0.
  - On valid&ready: tx_reg<=data, wr_n<=0, burst_cnt+=1.
- TX, write and skid:
  - The FT accepts a word on any edge with wr_n==0 and txe_n==0.
  - If wr_n==0 and txe_n==1: tx_reg and wr_n hold. This is a one-word skid; the word is never lost.
  - If the FT accepts the word and no new word is loaded: wr_n<=1.
- TX exit:
  - Leave TX for TX_DRAIN on the first edge where ready_g==0, or where valid_g==0 with ready_g==1.
  - Causes include burst_cnt==BURST_MAX, valid dropped, txe_n high, or rxf_n low (RX pre-empts).
- TX_DRAIN: no ready. Wait until wr_n==1, i.e. the pending word has been accepted, then go to IDLE. Arbitration restarts from IDLE.
- burst_cnt saturates at BURST_MAX and never wraps.
- oe_n and wr_n are never both low. oe_n changes only in IDLE, RX_OE or RX_END.

Decomposition:
- ft_bus_pkg holds:
  - state encoding localparams (IDLE=0, RX_OE=1, RX_RD=2, RX_END=3, TX=4, TX_DRAIN=5);
  - DATA_W/BE_W defaults;
  - channel index constants CH_ADC=0, CH_STAT=1.
- One sub-module is natural: ft_rr_arb2, a 2-way round-robin grant with a last_grant register, updated only on the IDLE->TX transition.

Test Plan:
- RX burst: after reset, rxf_n low for 3 words 0x1123, 0x2004, 0x8155, then high.
  - Required: oe_n falls 1 cycle before rd_n.
  - Exactly 3 o_rx_valid pulses with those words, in order.
  - oe_n returns to 1 one cycle after rd_n rises.
- TX0 stream: 5 words 0..4, txe_n low throughout.
  - Required: wr_n low for 5 consecutive cycles with data 0..4 and be=2'b11.
  - Then TX_DRAIN, then IDLE.
- Skid: txe_n goes high for 3 cycles while wr_n is low with word 0x0007.
  - Required: data holds 0x0007, ready stays 0, and the word is written exactly once after txe_n falls.
- Round-robin and burst: both channels valid continuously, BURST_MAX=4.
  - Required grants TX0, TX1, TX0, each exactly 4 words.
  - No ready on the non-granted channel.
- RX pre-emption: during a TX1 burst, rxf_n falls.
  - Required: ready drops the same cycle and the pending word completes.
  - RX_OE follows within 2 cycles of wr_n rising, and oe_n and wr_n are never low together.
- Async reset mid-TX: i_rst_n pulsed low between edges.
  - Required: oe_n, rd_n and wr_n are 1 and io_ft_data is driven 0 without waiting for a clock.
  - After release, the first grant goes to TX0.
